// File: rtl/dmem_ctrl.sv
// Data-memory access controller for the MEM stage.
// Drives a single-outstanding req/ack data bus and stalls the pipeline until done.
module dmem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_reg2_i,
  input  logic [4:0]  mem_wd_i,
  input  logic        mem_wreg_i,
  input  logic [31:0] mem_wdata_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  input  logic [31:0] bus_data_i,
  output logic        err_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'hE0;
  localparam logic [7:0] EXE_LH_OP  = 8'hE1;
  localparam logic [7:0] EXE_LW_OP  = 8'hE3;
  localparam logic [7:0] EXE_LBU_OP = 8'hE4;
  localparam logic [7:0] EXE_LHU_OP = 8'hE5;
  localparam logic [7:0] EXE_SB_OP  = 8'hE8;
  localparam logic [7:0] EXE_SH_OP  = 8'hE9;
  localparam logic [7:0] EXE_SW_OP  = 8'hEB;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_n;
  logic [31:0] data_q;
  logic        err_q;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        is_sext;
  logic        misal;
  logic [3:0]  sel_n;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    is_sext  = 1'b0;
    case (mem_aluop_i)
      EXE_LB_OP: begin
        is_load = 1'b1;
        is_byte = 1'b1;
        is_sext = 1'b1;
      end
      EXE_LH_OP: begin
        is_load = 1'b1;
        is_half = 1'b1;
        is_sext = 1'b1;
      end
      EXE_LW_OP: begin
        is_load = 1'b1;
        is_word = 1'b1;
      end
      EXE_LBU_OP: begin
        is_load = 1'b1;
        is_byte = 1'b1;
      end
      EXE_LHU_OP: begin
        is_load = 1'b1;
        is_half = 1'b1;
      end
      EXE_SB_OP: begin
        is_store = 1'b1;
        is_byte  = 1'b1;
      end
      EXE_SH_OP: begin
        is_store = 1'b1;
        is_half  = 1'b1;
      end
      EXE_SW_OP: begin
        is_store = 1'b1;
        is_word  = 1'b1;
      end
      default: ;
    endcase
  end

  assign is_mem = is_load | is_store;
  assign misal  = (is_half & mem_addr_i[0])
                | (is_word & (|mem_addr_i[1:0]));

  // Big-endian lanes: byte 0 lives in bits [31:24]
  always_comb begin
    sel_n   = 4'b0000;
    st_data = mem_reg2_i;
    unique case (1'b1)
      is_byte: begin
        st_data = {4{mem_reg2_i[7:0]}};
        case (mem_addr_i[1:0])
          2'd0:    sel_n = 4'b1000;
          2'd1:    sel_n = 4'b0100;
          2'd2:    sel_n = 4'b0010;
          default: sel_n = 4'b0001;
        endcase
      end
      is_half: begin
        st_data = {2{mem_reg2_i[15:0]}};
        sel_n   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      end
      is_word: sel_n = 4'b1111;
      default: ;
    endcase
  end

  always_comb begin
    case (mem_addr_i[1:0])
      2'd0:    ld_byte = data_q[31:24];
      2'd1:    ld_byte = data_q[23:16];
      2'd2:    ld_byte = data_q[15:8];
      default: ld_byte = data_q[7:0];
    endcase
    ld_half = mem_addr_i[1] ? data_q[15:0] : data_q[31:16];
    ld_data = data_q;
    unique case (1'b1)
      is_byte: ld_data = {{24{is_sext & ld_byte[7]}}, ld_byte};
      is_half: ld_data = {{16{is_sext & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bus_req_o  <= 1'b0;
      bus_we_o   <= 1'b0;
      bus_sel_o  <= 4'b0000;
      bus_addr_o <= 32'h0;
      bus_data_o <= 32'h0;
      data_q     <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (is_mem && !misal) begin
            bus_req_o  <= 1'b1;
            bus_we_o   <= is_store;
            bus_sel_o  <= sel_n;
            bus_addr_o <= {mem_addr_i[31:2], 2'b00};
            bus_data_o <= is_store ? st_data : 32'h0;
          end
        end
        BUSY: begin
          if (bus_ack_i || bus_err_i) begin
            bus_req_o <= 1'b0;
            bus_we_o  <= 1'b0;
            data_q    <= bus_data_i;
            err_q     <= bus_err_i;
          end
        end
        default: ;
      endcase
    end
  end

  // DONE never re-arms the bus, so a stalled op cannot issue twice
  always_comb begin
    state_n    = state;
    wd_o       = mem_wd_i;
    wreg_o     = mem_wreg_i;
    wdata_o    = mem_wdata_i;
    stallreq_o = 1'b0;
    err_o      = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem) begin
          wreg_o = 1'b0;
          if (misal) begin
            err_o = 1'b1;
          end else begin
            stallreq_o = 1'b1;
            state_n    = BUSY;
          end
        end
      end
      BUSY: begin
        stallreq_o = 1'b1;
        wreg_o     = 1'b0;
        if (bus_ack_i || bus_err_i) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
        err_o   = err_q;
        wreg_o  = (is_store || err_q) ? 1'b0 : mem_wreg_i;
        if (is_load) begin
          wdata_o = ld_data;
        end
      end
      default: state_n = IDLE;
    endcase
    if (rst) begin
      wd_o       = 5'd0;
      wreg_o     = 1'b0;
      wdata_o    = 32'h0;
      stallreq_o = 1'b0;
      err_o      = 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: vector table, directed corner sequences
// and random transactions against a size/offset arithmetic model.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mem_aluop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_reg2_i;
  logic [4:0]  mem_wd_i;
  logic        mem_wreg_i;
  logic [31:0] mem_wdata_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic        bus_ack_i;
  logic        bus_err_i;
  logic [31:0] bus_data_i;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  dmem_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_aluop_i(mem_aluop_i), .mem_addr_i(mem_addr_i),
    .mem_reg2_i(mem_reg2_i), .mem_wd_i(mem_wd_i),
    .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stallreq_o(stallreq_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
    .bus_data_o(bus_data_o),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i),
    .bus_data_i(bus_data_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        e_wreg;
    logic        e_stall;
    logic        e_err;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void op_info(input logic [7:0] op, output int sz,
                                  output bit ld, output bit sgn,
                                  output bit mem);
    sz = 4; ld = 0; sgn = 0; mem = 1;
    case (op)
      8'hE0: begin sz = 1; ld = 1; sgn = 1; end
      8'hE1: begin sz = 2; ld = 1; sgn = 1; end
      8'hE3: begin sz = 4; ld = 1; end
      8'hE4: begin sz = 1; ld = 1; end
      8'hE5: begin sz = 2; ld = 1; end
      8'hE8: sz = 1;
      8'hE9: sz = 2;
      8'hEB: sz = 4;
      default: mem = 0;
    endcase
  endfunction

  function automatic logic [3:0] m_sel(input int sz, input logic [31:0] a);
    int off = int'(a % 4);
    return 4'(((1 << sz) - 1) << (4 - sz - off));
  endfunction

  function automatic logic [31:0] m_store(input int sz, input logic [31:0] r);
    longint unsigned v, d;
    v = {32'h0, r} % (64'd1 << (8 * sz));
    d = 0;
    for (int i = 0; i < 4 / sz; i++) d = d + (v << (8 * sz * i));
    return d[31:0];
  endfunction

  function automatic logic [31:0] m_load(input int sz, input bit sgn,
                                         input logic [31:0] a,
                                         input logic [31:0] w);
    longint unsigned v;
    longint unsigned span;
    int sh = 8 * (4 - sz - int'(a % 4));
    span = 64'd1 << (8 * sz);
    v = ({32'h0, w} >> sh) % span;
    if (sgn && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  task automatic mem_txn(input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] reg2, input logic [4:0] wd,
                         input logic wreg, input int waits,
                         input logic [31:0] bdata, input logic berr,
                         input logic back);
    int sz;
    bit ld, sgn, mem;
    op_info(op, sz, ld, sgn, mem);
    mem_aluop_i = op; mem_addr_i = addr; mem_reg2_i = reg2;
    mem_wd_i = wd; mem_wreg_i = wreg; mem_wdata_i = $urandom;
    bus_ack_i = 1'($urandom); bus_err_i = 1'($urandom);
    bus_data_i = $urandom;
    @(negedge clk);
    if (int'(addr % 4) % sz != 0) begin
      chk("mis_stall", stallreq_o, 0);
      chk("mis_err", err_o, 1);
      chk("mis_wreg", wreg_o, 0);
      step();
      mem_aluop_i = 8'h21;
      @(negedge clk);
      chk("mis_noreq", bus_req_o, 0);
      chk("mis_errpulse", err_o, 0);
      step();
      return;
    end
    chk("idle_stall", stallreq_o, 1);
    chk("idle_err", err_o, 0);
    chk("idle_req", bus_req_o, 0);
    step();
    for (int i = 0; i <= waits; i++) begin
      bus_data_i = $urandom;
      bus_err_i  = (i == waits) ? berr : 1'b0;
      bus_ack_i  = (i == waits) ? (berr ? back : 1'b1) : 1'b0;
      if (i == waits) bus_data_i = bdata;
      @(negedge clk);
      chk("busy_req", bus_req_o, 1);
      chk("busy_stall", stallreq_o, 1);
      chk("busy_addr", bus_addr_o, addr - (addr % 4));
      chk("busy_sel", bus_sel_o, m_sel(sz, addr));
      chk("busy_we", bus_we_o, !ld);
      if (!ld) chk("busy_data", bus_data_o, m_store(sz, reg2));
      step();
    end
    bus_ack_i = 1'($urandom); bus_err_i = 1'($urandom);
    bus_data_i = $urandom;
    @(negedge clk);
    chk("done_stall", stallreq_o, 0);
    chk("done_req", bus_req_o, 0);
    chk("done_we", bus_we_o, 0);
    chk("done_err", err_o, berr);
    chk("done_wd", wd_o, wd);
    chk("done_wreg", wreg_o, (ld && !berr) ? wreg : 1'b0);
    if (ld && !berr) chk("done_wdata", wdata_o, m_load(sz, sgn, addr, bdata));
    step();
    bus_ack_i = 1'b0; bus_err_i = 1'b0;
  endtask

  task automatic alu_txn(input logic [7:0] op);
    logic [31:0] d = $urandom;
    logic [4:0]  w = 5'($urandom);
    logic        e = 1'($urandom);
    mem_aluop_i = op; mem_addr_i = $urandom; mem_reg2_i = $urandom;
    mem_wd_i = w; mem_wreg_i = e; mem_wdata_i = d;
    bus_ack_i = 1'($urandom); bus_err_i = 1'($urandom);
    @(negedge clk);
    chk("alu_wd", wd_o, w);
    chk("alu_wreg", wreg_o, e);
    chk("alu_wdata", wdata_o, d);
    chk("alu_stall", stallreq_o, 0);
    chk("alu_req", bus_req_o, 0);
    step();
  endtask

  initial begin
    logic [7:0] ops[8];
    ops = '{8'hE0, 8'hE1, 8'hE3, 8'hE4, 8'hE5, 8'hE8, 8'hE9, 8'hEB};
    vt[0] = '{8'h21, 32'h0,  5'd5,  1'b1, 32'h1234,     1'b1, 1'b0, 1'b0};
    vt[1] = '{8'h00, 32'h3,  5'd1,  1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
    vt[2] = '{8'hFF, 32'h8,  5'd31, 1'b0, 32'h5,        1'b0, 1'b0, 1'b0};
    vt[3] = '{8'hE2, 32'h4,  5'd7,  1'b1, 32'h77,       1'b1, 1'b0, 1'b0};
    vt[4] = '{8'hE3, 32'h6,  5'd9,  1'b1, 32'h99,       1'b0, 1'b0, 1'b1};
    vt[5] = '{8'hE1, 32'h3,  5'd2,  1'b1, 32'h22,       1'b0, 1'b0, 1'b1};
    vt[6] = '{8'hEB, 32'h2,  5'd3,  1'b0, 32'h33,       1'b0, 1'b0, 1'b1};
    vt[7] = '{8'hE9, 32'h1,  5'd4,  1'b0, 32'h44,       1'b0, 1'b0, 1'b1};
    vt[8] = '{8'hE5, 32'h11, 5'd6,  1'b1, 32'h66,       1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    mem_aluop_i = 8'hE3; mem_addr_i = 32'h40; mem_reg2_i = $urandom;
    mem_wd_i = 5'd9; mem_wreg_i = 1'b1; mem_wdata_i = $urandom;
    bus_ack_i = 1'b1; bus_err_i = 1'b1; bus_data_i = $urandom;
    step();
    @(negedge clk);
    chk("rst_wd", wd_o, 0);
    chk("rst_wreg", wreg_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_stall", stallreq_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_req", bus_req_o, 0);
    chk("rst_sel", bus_sel_o, 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_bdata", bus_data_o, 0);
    step();
    rst = 1'b0;
    bus_ack_i = 1'b0; bus_err_i = 1'b0;

    for (int i = 0; i < 9; i++) begin
      mem_aluop_i = vt[i].op; mem_addr_i = vt[i].addr;
      mem_wd_i = vt[i].wd; mem_wreg_i = vt[i].wreg;
      mem_wdata_i = vt[i].wdata; bus_ack_i = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_wd", i), wd_o, vt[i].wd);
      chk($sformatf("vec%0d_wreg", i), wreg_o, vt[i].e_wreg);
      chk($sformatf("vec%0d_wdata", i), wdata_o, vt[i].wdata);
      chk($sformatf("vec%0d_stall", i), stallreq_o, vt[i].e_stall);
      chk($sformatf("vec%0d_err", i), err_o, vt[i].e_err);
      chk($sformatf("vec%0d_req", i), bus_req_o, 0);
      step();
    end
    bus_ack_i = 1'b0;

    mem_txn(8'hE0, 32'h101, 32'h0, 5'd3, 1'b1, 1, 32'h11F23344, 1'b0, 1'b1);
    mem_txn(8'hE9, 32'h202, 32'hAAAA5678, 5'd4, 1'b1, 0, 32'h0, 1'b0, 1'b1);
    mem_txn(8'hE3, 32'h6, 32'h0, 5'd5, 1'b1, 0, 32'h0, 1'b0, 1'b1);
    mem_txn(8'hE5, 32'h10, 32'h0, 5'd6, 1'b1, 0, 32'h12345678, 1'b1, 1'b1);
    mem_txn(8'hE3, 32'h20, 32'h0, 5'd7, 1'b1, 2, 32'hCAFEF00D, 1'b0, 1'b1);

    mem_aluop_i = 8'hE3; mem_addr_i = 32'h40; mem_wreg_i = 1'b1;
    bus_ack_i = 1'b0; bus_err_i = 1'b0;
    step();
    @(negedge clk);
    chk("mid_busy_req", bus_req_o, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_wd", wd_o, 0);
    chk("mid_rst_wreg", wreg_o, 0);
    chk("mid_rst_wdata", wdata_o, 0);
    chk("mid_rst_stall", stallreq_o, 0);
    chk("mid_rst_err", err_o, 0);
    step();
    rst = 1'b0; bus_ack_i = 1'b1; mem_aluop_i = 8'h21;
    @(negedge clk);
    chk("post_rst_req", bus_req_o, 0);
    chk("post_rst_stall", stallreq_o, 0);
    chk("post_rst_wreg", wreg_o, 1);
    step();
    bus_ack_i = 1'b0;
    mem_txn(8'hE3, 32'h80, 32'h0, 5'd8, 1'b1, 0, 32'h0BADBEEF, 1'b0, 1'b1);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [7:0] o;
        bit m;
        int s;
        bit l, g;
        do begin
          o = 8'($urandom);
          op_info(o, s, l, g, m);
        end while (m);
        alu_txn(o);
      end else begin
        mem_txn(ops[$urandom_range(0, 7)], $urandom, $urandom,
                5'($urandom), 1'($urandom), $urandom_range(0, 3),
                $urandom, ($urandom_range(0, 5) == 0), 1'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
